// File: rtl/traffic_lights_multi_if.sv
// Command bus of the multi-channel traffic light controller.
// The board-level register wrapper drives it through the master modport.
interface traffic_lights_multi_if #(
  parameter int CH_W = 2
);
  logic [2:0]      cmd_type_i;
  logic            cmd_valid_i;
  logic [CH_W-1:0] cmd_chan_i;
  logic [15:0]     cmd_data_i;

  modport master (output cmd_type_i, cmd_valid_i, cmd_chan_i, cmd_data_i);
  modport slave  (input  cmd_type_i, cmd_valid_i, cmd_chan_i, cmd_data_i);
endinterface

// File: rtl/traffic_lights_multi.sv
// Multi-channel traffic light controller: N_CH signal heads share one
// round-robin schedule, with green/yellow times programmable per channel.
// Optional macro TRAFFIC_LIGHTS_CMD_ERR_EN adds cmd_err_o, a one-cycle
// pulse for every valid command that is ignored.
module traffic_lights_multi #(
  parameter int N_CH                  = 4,
  parameter int CLK_FREQ_KHZ          = 2,
  parameter int BLINK_HALF_PERIOD_MS  = 3,
  parameter int BLINK_GREEN_TIME_TICK = 4,
  parameter int RED_YELLOW_MS         = 7,
  parameter int DEF_GREEN_MS          = 10,
  parameter int DEF_YELLOW_MS         = 5,
  parameter int DEF_ALL_RED_MS        = 2,
  parameter int CH_W                  = $clog2(N_CH)
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  traffic_lights_multi_if.slave cmd,
  output logic [N_CH-1:0]       red_o,
  output logic [N_CH-1:0]       yellow_o,
  output logic [N_CH-1:0]       green_o,
  output logic [CH_W-1:0]       active_ch_o
`ifdef TRAFFIC_LIGHTS_CMD_ERR_EN
  ,
  output logic                  cmd_err_o
`endif
);

  localparam int PRE_W = (CLK_FREQ_KHZ > 1) ? $clog2(CLK_FREQ_KHZ) : 1;
  localparam int HB_W  = $clog2(BLINK_HALF_PERIOD_MS + 1);
  localparam int NSLOT = 1 << CH_W;
  // One bit per encodable channel number: set where the channel exists.
  localparam logic [NSLOT-1:0] CH_OK     = NSLOT'((33'(1) << N_CH) - 33'(1));
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_FREQ_KHZ - 1);
  localparam logic [HB_W-1:0]  HALF      = HB_W'(BLINK_HALF_PERIOD_MS);
  localparam logic [15:0]      RY_LEN    = 16'(RED_YELLOW_MS);
  localparam logic [15:0]      BLINK_LEN = 16'(2 * BLINK_HALF_PERIOD_MS * BLINK_GREEN_TIME_TICK);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {MODE_OFF, MODE_RUN, MODE_UNREG} mode_e;
  typedef enum logic [2:0] {PH_ALL_RED, PH_RED_YELLOW, PH_GREEN, PH_GREEN_BLINK, PH_YELLOW} phase_e;
  typedef enum logic [2:0] {
    CMD_ON, CMD_OFF, CMD_UNREG, CMD_SET_GREEN, CMD_SET_YELLOW, CMD_SET_ALL_RED
  } cmd_e;

  // Reset: asserted asynchronously, released through two flops.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Reset synchroniser.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) rst_sync_q <= '0;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Timing registers.
  logic [15:0] green_ms_q  [N_CH];
  logic [15:0] yellow_ms_q [N_CH];
  logic [15:0] all_red_ms_q;

  mode_e             mode_q, mode_n;
  phase_e            phase_q, phase_n;
  logic [CH_W-1:0]   ch_q, ch_n;
  logic [15:0]       ms_q, ms_n;
  logic [PRE_W-1:0]  pre_q, pre_n;
  logic [HB_W-1:0]   hb_q, hb_n;
  logic              blink_q, blink_n;
  logic [N_CH-1:0]   red_d, yel_d, grn_d;

  logic        tick, set_en, set_chan_ok, preempt;
  logic [15:0] set_val;

  assign tick        = (pre_q == PRE_LAST);
  assign set_en      = cmd.cmd_valid_i && (mode_q == MODE_UNREG);
  assign set_chan_ok = CH_OK[cmd.cmd_chan_i];
  assign set_val     = (cmd.cmd_data_i == 16'd0) ? 16'd1 : cmd.cmd_data_i;
  assign preempt     = cmd.cmd_valid_i &&
                       (cmd.cmd_type_i == CMD_OFF || cmd.cmd_type_i == CMD_UNREG);

  // Set commands update the timing registers, only while in UNREG.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the timing array is small and has defined defaults, so every
      // entry is reset explicitly; it must not be mapped to a RAM.
      for (int i = 0; i < N_CH; i++) begin
        green_ms_q[i]  <= 16'(DEF_GREEN_MS);
        yellow_ms_q[i] <= 16'(DEF_YELLOW_MS);
      end
      all_red_ms_q <= 16'(DEF_ALL_RED_MS);
    end else if (set_en) begin
      case (cmd.cmd_type_i)
        CMD_SET_GREEN:   if (set_chan_ok) green_ms_q[cmd.cmd_chan_i]  <= set_val;
        CMD_SET_YELLOW:  if (set_chan_ok) yellow_ms_q[cmd.cmd_chan_i] <= set_val;
        CMD_SET_ALL_RED: all_red_ms_q <= set_val;
        default: ;
      endcase
    end
  end

  // Next state: ms timebase, blink timer, phase advance, then commands win.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    mode_n  = mode_q;
    phase_n = phase_q;
    ch_n    = ch_q;
    ms_n    = ms_q;
    hb_n    = hb_q;
    blink_n = blink_q;
    pre_n   = tick ? '0 : pre_q + 1'b1;

    if (tick && mode_q != MODE_OFF) begin
      if (hb_q == HB_W'(1)) begin
        hb_n    = HALF;
        blink_n = ~blink_q;
      end else begin
        hb_n = hb_q - 1'b1;
      end
    end

    if (tick && mode_q == MODE_RUN && !preempt) begin
      if (ms_q == 16'd1) begin
        // Phase entry: blink restarts in its "off" half for GREEN_BLINK.
        hb_n    = HALF;
        blink_n = 1'b0;
        case (phase_q)
          PH_ALL_RED:     begin phase_n = PH_RED_YELLOW;  ms_n = RY_LEN;            end
          PH_RED_YELLOW:  begin phase_n = PH_GREEN;       ms_n = green_ms_q[ch_q];  end
          PH_GREEN:       begin phase_n = PH_GREEN_BLINK; ms_n = BLINK_LEN;         end
          PH_GREEN_BLINK: begin phase_n = PH_YELLOW;      ms_n = yellow_ms_q[ch_q]; end
          default: begin
            phase_n = PH_ALL_RED;
            ms_n    = all_red_ms_q;
            ch_n    = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
          end
        endcase
      end else begin
        ms_n = ms_q - 16'd1;
      end
    end

    if (cmd.cmd_valid_i) begin
      case (cmd.cmd_type_i)
        CMD_ON: if (mode_q != MODE_RUN) begin
          mode_n  = MODE_RUN;
          phase_n = PH_ALL_RED;
          ch_n    = '0;
          ms_n    = all_red_ms_q;
          pre_n   = '0;
          hb_n    = HALF;
          blink_n = 1'b0;
        end
        CMD_OFF: mode_n = MODE_OFF;
        CMD_UNREG: begin
          mode_n  = MODE_UNREG;
          pre_n   = '0;
          hb_n    = HALF;
          blink_n = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Lamp pattern derived from the next state, so lamps register with it.
  always_comb begin
    red_d = '0;
    yel_d = '0;
    grn_d = '0;
    case (mode_n)
      MODE_UNREG: yel_d = {N_CH{blink_n}};
      MODE_RUN: begin
        red_d = '1;
        case (phase_n)
          PH_RED_YELLOW:  yel_d[ch_n] = 1'b1;
          PH_GREEN:       begin red_d[ch_n] = 1'b0; grn_d[ch_n] = 1'b1;    end
          PH_GREEN_BLINK: begin red_d[ch_n] = 1'b0; grn_d[ch_n] = blink_n; end
          PH_YELLOW:      begin red_d[ch_n] = 1'b0; yel_d[ch_n] = 1'b1;    end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Mode/phase FSM with registered lamp outputs.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_OFF;
      phase_q     <= PH_ALL_RED;
      ch_q        <= '0;
      ms_q        <= '0;
      pre_q       <= '0;
      hb_q        <= '0;
      blink_q     <= 1'b0;
      red_o       <= '0;
      yellow_o    <= '0;
      green_o     <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples values from before this edge.
      mode_q      <= mode_n;
      phase_q     <= phase_n;
      ch_q        <= ch_n;
      ms_q        <= ms_n;
      pre_q       <= pre_n;
      hb_q        <= hb_n;
      blink_q     <= blink_n;
      red_o       <= red_d;
      yellow_o    <= yel_d;
      green_o     <= grn_d;
    end
  end

  assign active_ch_o = ch_q;

`ifdef TRAFFIC_LIGHTS_CMD_ERR_EN
  logic cmd_ignored;

  // Classify the current command as ignored against the pre-command mode.
  always_comb begin
    cmd_ignored = 1'b0;
    if (cmd.cmd_valid_i) begin
      case (cmd.cmd_type_i)
        CMD_ON:                        cmd_ignored = (mode_q == MODE_RUN);
        CMD_OFF, CMD_UNREG:            cmd_ignored = 1'b0;
        CMD_SET_GREEN, CMD_SET_YELLOW: cmd_ignored = (mode_q != MODE_UNREG) || !set_chan_ok;
        CMD_SET_ALL_RED:               cmd_ignored = (mode_q != MODE_UNREG);
        default:                       cmd_ignored = 1'b1;
      endcase
    end
  end

  // One-cycle error pulse.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) cmd_err_o <= 1'b0;
    else        cmd_err_o <= cmd_ignored;
  end
`endif

endmodule

// File: tb/tb_traffic_lights_multi.sv
// Self-checking bench for traffic_lights_multi (N_CH=4, CLK_FREQ_KHZ=2).
// A schedule model compares every lamp on every falling edge; directed
// literal checks pin the model at known instants.
module tb_traffic_lights_multi;

  localparam int N_CH = 4;
  localparam int CLK  = 2;
  localparam int H    = 3;
  localparam int TICK = 4;

  logic       clk_i    = 1'b0;
  logic       arst_n_i = 1'b0;
  logic [3:0] red_o, yellow_o, green_o;
  logic [1:0] active_ch_o;
`ifdef TRAFFIC_LIGHTS_CMD_ERR_EN
  logic       cmd_err_o;
`endif

  traffic_lights_multi_if #(.CH_W(2)) bus ();

  traffic_lights_multi #(
    .N_CH(N_CH), .CLK_FREQ_KHZ(CLK), .BLINK_HALF_PERIOD_MS(H),
    .BLINK_GREEN_TIME_TICK(TICK), .RED_YELLOW_MS(7), .DEF_GREEN_MS(10),
    .DEF_YELLOW_MS(5), .DEF_ALL_RED_MS(2)
  ) dut (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .cmd         (bus),
    .red_o       (red_o),
    .yellow_o    (yellow_o),
    .green_o     (green_o),
    .active_ch_o (active_ch_o)
`ifdef TRAFFIC_LIGHTS_CMD_ERR_EN
    ,
    .cmd_err_o   (cmd_err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Schedule model: mode 0=OFF 1=RUN 2=UNREG; phase 0..4 in schedule order;
  // m_t counts cycles inside the phase, m_ut cycles since UNREG entry.
  int   m_mode, m_ch, m_ph, m_t, m_ut, m_allred;
  int   m_green [N_CH];
  int   m_yellow[N_CH];
  logic m_err;

  function automatic int ph_cycles(int ph, int ch);
    case (ph)
      0:       return m_allred * CLK;
      1:       return 7 * CLK;
      2:       return m_green[ch] * CLK;
      3:       return 2 * H * TICK * CLK;
      default: return m_yellow[ch] * CLK;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ch = 0; m_ph = 0; m_t = 0; m_ut = 0; m_allred = 2; m_err = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      m_green[i]  = 10;
      m_yellow[i] = 5;
    end
  endtask

  // Model update on every rising edge from the command seen in that cycle.
  initial begin
    int v;
    bit changed;
    model_reset();
    forever begin
      @(posedge clk_i or negedge arst_n_i);
      if (!arst_n_i) begin
        model_reset();
      end else begin
        changed = 0;
        m_err   = 1'b0;
        if (bus.cmd_valid_i) begin
          v = (bus.cmd_data_i == 16'd0) ? 1 : int'(bus.cmd_data_i);
          case (int'(bus.cmd_type_i))
            0: if (m_mode != 1) begin
                 m_mode = 1; m_ch = 0; m_ph = 0; m_t = 0; changed = 1;
               end else m_err = 1'b1;
            1: begin m_mode = 0; changed = 1; end
            2: begin m_mode = 2; m_ut = 0; changed = 1; end
            3: if (m_mode == 2) m_green[bus.cmd_chan_i]  = v; else m_err = 1'b1;
            4: if (m_mode == 2) m_yellow[bus.cmd_chan_i] = v; else m_err = 1'b1;
            5: if (m_mode == 2) m_allred = v;                 else m_err = 1'b1;
            default: m_err = 1'b1;
          endcase
        end
        if (!changed) begin
          if (m_mode == 1) begin
            m_t++;
            if (m_t == ph_cycles(m_ph, m_ch)) begin
              m_t = 0;
              if (m_ph == 4) begin
                m_ph = 0;
                m_ch = (m_ch + 1) % N_CH;
              end else begin
                m_ph++;
              end
            end
          end else if (m_mode == 2) begin
            m_ut++;
          end
        end
      end
    end
  end

  // Compare process: every falling edge once checking is enabled.
  bit chk_en = 0;
  initial begin
    logic [3:0] er, ey, eg;
    forever begin
      @(negedge clk_i);
      if (chk_en) begin
        er = '0; ey = '0; eg = '0;
        if (m_mode == 2) begin
          ey = (((m_ut / (H * CLK)) % 2) == 0) ? 4'hF : 4'h0;
        end else if (m_mode == 1) begin
          er = 4'hF;
          case (m_ph)
            1: ey[2'(m_ch)] = 1'b1;
            2: begin er[2'(m_ch)] = 1'b0; eg[2'(m_ch)] = 1'b1; end
            3: begin er[2'(m_ch)] = 1'b0; eg[2'(m_ch)] = ((m_t / (H * CLK)) % 2) == 1; end
            4: begin er[2'(m_ch)] = 1'b0; ey[2'(m_ch)] = 1'b1; end
            default: ;
          endcase
        end
        check("model_red",    32'(red_o),       32'(er));
        check("model_yellow", 32'(yellow_o),    32'(ey));
        check("model_green",  32'(green_o),     32'(eg));
        check("model_active", 32'(active_ch_o), 32'(m_ch));
        if (m_mode == 1)
          check("one_go", 32'($countones(~red_o | yellow_o | green_o) <= 1), 32'd1);
`ifdef TRAFFIC_LIGHTS_CMD_ERR_EN
        check("model_cmd_err", 32'(cmd_err_o), 32'(m_err));
`endif
      end
    end
  end

  task automatic send(input int typ, input int chan, input int data);
    bus.cmd_type_i  = 3'(typ);
    bus.cmd_chan_i  = 2'(chan);
    bus.cmd_data_i  = 16'(data);
    bus.cmd_valid_i = 1'b1;
    @(negedge clk_i);
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_type_i  = '0;
    bus.cmd_chan_i  = '0;
    bus.cmd_data_i  = '0;
    #23 arst_n_i = 1'b1;
    @(negedge clk_i);
    chk_en = 1;
    check("reset_red", 32'(red_o), 32'h0);
    check("reset_active", 32'(active_ch_o), 32'h0);
    step(4);
    check("idle_off_lamps", 32'(red_o | yellow_o | green_o), 32'h0);

    // ON sequence, k counts cycles from the first output change.
    send(0, 0, 0);                                         // k=0
    check("on_all_red", 32'(red_o), 32'hF);
    step(4);                                               // k=4
    check("ch0_red_yellow", 32'(yellow_o), 32'h1);
    check("ch0_ry_red", 32'(red_o), 32'hF);
    step(14);                                              // k=18
    check("ch0_green", 32'(green_o), 32'h1);
    check("ch0_green_red", 32'(red_o), 32'hE);
    step(20);                                              // k=38
    check("ch0_blink_off", 32'(green_o), 32'h0);
    step(6);                                               // k=44
    check("ch0_blink_on", 32'(green_o), 32'h1);
    step(42);                                              // k=86
    check("ch0_yellow", 32'(yellow_o), 32'h1);
    step(10);                                              // k=96
    check("ch1_all_red", 32'(red_o), 32'hF);
    check("ch1_active", 32'(active_ch_o), 32'h1);

    // Ignored commands during RUN.
    send(3, 1, 50);                                        // k=97
`ifdef TRAFFIC_LIGHTS_CMD_ERR_EN
    check("err_set_in_run", 32'(cmd_err_o), 32'h1);
`endif
    send(6, 0, 0);                                         // k=98
    send(7, 0, 0);                                         // k=99
    step(15);                                              // k=114
    check("ch1_green", 32'(green_o), 32'h2);

    // OFF mid-GREEN of ch1.
    step(6);                                               // k=120
    send(1, 0, 0);                                         // k=121
    check("off_lamps", 32'(red_o | yellow_o | green_o), 32'h0);

    // UNREG blink and per-channel configuration.
    send(2, 0, 0);                                         // u=0
    check("unreg_on", 32'(yellow_o), 32'hF);
    check("unreg_red", 32'(red_o), 32'h0);
    step(5);
    check("unreg_on_last", 32'(yellow_o), 32'hF);
    step(1);
    check("unreg_off", 32'(yellow_o), 32'h0);
    step(5);
    check("unreg_off_last", 32'(yellow_o), 32'h0);
    step(1);
    check("unreg_on_again", 32'(yellow_o), 32'hF);
    send(3, 2, 3);
`ifdef TRAFFIC_LIGHTS_CMD_ERR_EN
    check("err_set_in_unreg", 32'(cmd_err_o), 32'h0);
`endif
    send(4, 3, 0);                                         // yellow[3] = 1 ms

    // Wrap-around run: ch0 96, ch1 96, ch2 82, ch3 88 cycles.
    send(0, 0, 0);                                         // k=0
    check("run2_active0", 32'(active_ch_o), 32'h0);
    step(210);                                             // k=210
    check("ch2_green", 32'(green_o), 32'h4);
    check("ch2_active", 32'(active_ch_o), 32'h2);
    step(5);                                               // k=215
    check("ch2_green_last", 32'(green_o), 32'h4);
    step(1);                                               // k=216
    check("ch2_blink_start", 32'(green_o), 32'h0);
    step(58);                                              // k=274
    check("ch3_active", 32'(active_ch_o), 32'h3);
    step(86);                                              // k=360
    check("ch3_yellow_short", 32'(yellow_o), 32'h8);
    step(2);                                               // k=362
    check("wrap_active0", 32'(active_ch_o), 32'h0);
    check("wrap_all_red", 32'(red_o), 32'hF);

    // UNREG on the last cycle of ch0 YELLOW pre-empts ALL_RED.
    step(95);                                              // k=457
    check("ch0_yellow_last", 32'(yellow_o), 32'h1);
    send(2, 0, 0);
    check("preempt_unreg_yellow", 32'(yellow_o), 32'hF);
    check("preempt_unreg_red", 32'(red_o), 32'h0);

    // Asynchronous reset mid-GREEN of ch1.
    send(0, 0, 0);                                         // k=0
    step(120);                                             // k=120
    check("pre_reset_green", 32'(green_o), 32'h2);
    #2 arst_n_i = 1'b0;
    #1;
    check("async_reset_lamps", 32'(red_o | yellow_o | green_o), 32'h0);
    check("async_reset_active", 32'(active_ch_o), 32'h0);
    step(3);
    #2 arst_n_i = 1'b1;
    step(6);
    check("post_reset_off", 32'(red_o | yellow_o | green_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
